// File: rtl/board_move_collector.sv
// Board-level move collector: drains the eight column move FIFOs round-robin,
// unpacks each 160-bit word into 19-bit moves and streams the valid ones out.
module board_move_collector (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           col_done,
    input  logic [7:0]           col_empty,
    input  logic [1279:0]        col_data,
    output logic [7:0]           col_rden,
    output logic [18:0]          move_out,
    output logic                 move_valid,
    input  logic                 move_ready,
    output logic [7:0]           move_count,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned NCOL  = 8;
    localparam int unsigned WORDW = 160;
    localparam int unsigned SLOTW = 20;
    localparam int unsigned NSLOT = 8;
    localparam int unsigned MOVEW = 19;
    localparam int unsigned PTRW  = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        REQ    = 3'd2,
        LATCH  = 3'd3,
        UNPACK = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [PTRW-1:0]     col_ptr_q, col_ptr_d;
    logic [NCOL-1:0]     drained_q, drained_d;
    logic [PTRW-1:0]     slot_idx_q, slot_idx_d;
    logic [WORDW-1:0]    word_q, word_d;
    logic [NCOL-1:0]     col_rden_d;
    logic [MOVEW-1:0]    move_out_d;
    logic                move_valid_d;
    logic [7:0]          move_count_d;
    logic                busy_d;
    logic                done_d;

    logic [WORDW-1:0]    cur_word;
    logic [PTRW-1:0]     next_slot;
    logic [MOVEW-1:0]    next_move;

    // Word of the addressed column and the move in the following slot of the buffer
    always_comb begin
        cur_word  = col_data[int'(col_ptr_q) * WORDW +: WORDW];
        next_slot = PTRW'(slot_idx_q + 3'd1);
        next_move = word_q[int'(next_slot) * SLOTW +: MOVEW];
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        col_ptr_d    = col_ptr_q;
        drained_d    = drained_q;
        slot_idx_d   = slot_idx_q;
        word_d       = word_q;
        col_rden_d   = '0;
        move_out_d   = move_out;
        move_valid_d = move_valid;
        move_count_d = move_count;

        if (move_valid && move_ready && move_count != 8'hFF) begin
            move_count_d = 8'(move_count + 8'd1);
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    col_ptr_d    = '0;
                    drained_d    = '0;
                    move_count_d = '0;
                    state_d      = SCAN;
                end
            end
            SCAN: begin
                if (drained_q[col_ptr_q]) begin
                    col_ptr_d = PTRW'(col_ptr_q + 3'd1);
                end else if (!col_empty[col_ptr_q]) begin
                    col_rden_d = NCOL'(8'd1 << col_ptr_q);
                    state_d    = REQ;
                end else begin
                    if (col_done[col_ptr_q]) begin
                        drained_d[col_ptr_q] = 1'b1;
                    end
                    col_ptr_d = PTRW'(col_ptr_q + 3'd1);
                end
                if (drained_d == '1) begin
                    state_d = DONE;
                end
            end
            REQ: begin
                state_d = LATCH;
            end
            LATCH: begin
                // Slot 0 is presented straight from the FIFO q to save a cycle
                word_d       = cur_word;
                slot_idx_d   = '0;
                move_out_d   = cur_word[MOVEW-1:0];
                move_valid_d = !cur_word[MOVEW-1];
                state_d      = UNPACK;
            end
            UNPACK: begin
                if (!(move_valid && !move_ready)) begin
                    if (slot_idx_q == PTRW'(NSLOT - 1)) begin
                        move_valid_d = 1'b0;
                        state_d      = SCAN;
                    end else begin
                        slot_idx_d   = next_slot;
                        move_out_d   = next_move;
                        move_valid_d = !next_move[MOVEW-1];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            col_ptr_q  <= '0;
            drained_q  <= '0;
            slot_idx_q <= '0;
            word_q     <= '0;
            col_rden   <= '0;
            move_out   <= '0;
            move_valid <= 1'b0;
            move_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_ptr_q  <= col_ptr_d;
            drained_q  <= drained_d;
            slot_idx_q <= slot_idx_d;
            word_q     <= word_d;
            col_rden   <= col_rden_d;
            move_out   <= move_out_d;
            move_valid <= move_valid_d;
            move_count <= move_count_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule
